// File: rtl/pulse_burst_sched.sv
// pulse_burst_sched: walks a programmed list of burst descriptors. It loads each
// valid descriptor onto the pulse generator, strobes start, waits for done, and
// repeats the whole list loop_cnt times (0 = until abort).
//
// Generator handshake: pg_*_o are stable from LOAD entry until the next LOAD.
// pg_start_o is a level held START_HOLD cycles after SETUP_CYC setup cycles.
// pg_done_i is level-sampled only in WAIT_DONE, which begins after start drops.
module pulse_burst_sched #(
   parameter int DEPTH      = 8,
   parameter int AW         = $clog2(DEPTH),
   parameter int SETUP_CYC  = 4,
   parameter int START_HOLD = 4,
   parameter int TIMEOUT_W  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_we_i,
   input  logic [AW-1:0]        cfg_addr_i,
   input  logic [10:0]          cfg_width_i,
   input  logic [10:0]          cfg_num_i,
   input  logic [15:0]          cfg_gap_i,
   input  logic [AW:0]          seq_len_i,
   input  logic [7:0]           loop_cnt_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   input  logic                 run_i,
   input  logic                 abort_i,
   output logic [10:0]          pg_width_o,
   output logic [10:0]          pg_num_o,
   output logic [15:0]          pg_gap_o,
   output logic                 pg_start_o,
   input  logic                 pg_done_i,
   output logic                 busy_o,
   output logic [AW-1:0]        cur_idx_o,
   output logic [7:0]           loop_idx_o,
   output logic                 seq_done_o,
   output logic                 err_o
);

   localparam int LEN_W = AW + 1;
   localparam logic [TIMEOUT_W-1:0] SETUP_LAST = TIMEOUT_W'(SETUP_CYC - 1);
   localparam logic [TIMEOUT_W-1:0] HOLD_LAST  = TIMEOUT_W'(START_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_WAIT   = 3'd4,
      S_NEXT   = 3'd5,
      S_FINISH = 3'd6
   } state_e;

   typedef struct packed {
      logic [10:0] width;
      logic [10:0] num;
      logic [15:0] gap;
   } desc_t;

   desc_t                desc_mem [DEPTH];
   desc_t                rd_desc;
   logic                 rd_valid;
   logic                 start_ev;
   logic [LEN_W-1:0]     len_eff;

   state_e               state_q, state_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic                 run_q;
   logic [AW-1:0]        last_q, last_d;
   logic [7:0]           loop_cnt_q, loop_cnt_d;
   logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
   logic [AW-1:0]        cur_idx_q, cur_idx_d;
   logic [7:0]           loop_idx_q, loop_idx_d;
   logic                 err_q, err_d;
   logic                 any_valid_q, any_valid_d;
   logic [10:0]          pg_width_q, pg_width_d;
   logic [10:0]          pg_num_q, pg_num_d;
   logic [15:0]          pg_gap_q, pg_gap_d;

   // Descriptor store: writes accepted only while idle; contents not reset.
   always_ff @(posedge clk) begin
      if (cfg_we_i && !busy_o) begin
         desc_mem[cfg_addr_i] <= {cfg_width_i, cfg_num_i, cfg_gap_i};
      end
   end

   assign rd_desc  = desc_mem[cur_idx_q];
   // A zero gap would wrap the generator's microsecond counter, so it is invalid too.
   assign rd_valid = (|rd_desc.width) && (|rd_desc.num) && (|rd_desc.gap);
   assign start_ev = (state_q == S_IDLE) && run_i && !run_q;

   // Clamp the requested list length into 1..DEPTH.
   always_comb begin
      len_eff = seq_len_i;
      if (seq_len_i == '0) begin
         len_eff = LEN_W'(1);
      end else if (seq_len_i > LEN_W'(DEPTH)) begin
         len_eff = LEN_W'(DEPTH);
      end
   end

   // Sequencer next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      loop_cnt_d  = loop_cnt_q;
      timeout_d   = timeout_q;
      cur_idx_d   = cur_idx_q;
      loop_idx_d  = loop_idx_q;
      err_d       = err_q;
      any_valid_d = any_valid_q;
      pg_width_d  = pg_width_q;
      pg_num_d    = pg_num_q;
      pg_gap_d    = pg_gap_q;
      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d     = S_CHECK;
               last_d      = AW'(len_eff - LEN_W'(1));
               loop_cnt_d  = loop_cnt_i;
               timeout_d   = timeout_i;
               err_d       = 1'b0;
               cur_idx_d   = '0;
               loop_idx_d  = '0;
               any_valid_d = 1'b0;
            end
         end
         S_CHECK: begin
            if (rd_valid) begin
               any_valid_d = 1'b1;
               pg_width_d  = rd_desc.width;
               pg_num_d    = rd_desc.num;
               pg_gap_d    = rd_desc.gap;
               cnt_d       = '0;
               state_d     = S_LOAD;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_LOAD: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = S_START;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         S_START: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         S_WAIT: begin
            if (pg_done_i) begin
               state_d = S_NEXT;
            end else if ((timeout_q != '0) && (cnt_q >= timeout_q - TIMEOUT_W'(1))) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         S_NEXT: begin
            if (abort_i) begin
               state_d = S_FINISH;
            end else if (cur_idx_q == last_q) begin
               cur_idx_d   = '0;
               any_valid_d = 1'b0;
               if (loop_idx_q != 8'hFF) begin
                  loop_idx_d = loop_idx_q + 8'd1;
               end
               // A pass with no valid descriptor ends the run even in endless mode.
               if (!any_valid_q) begin
                  state_d = S_FINISH;
               end else if ((loop_cnt_q != 8'd0) &&
                            (({1'b0, loop_idx_q} + 9'd1) == {1'b0, loop_cnt_q})) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_CHECK;
               end
            end else begin
               cur_idx_d = cur_idx_q + AW'(1);
               state_d   = S_CHECK;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops start and busy immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         run_q       <= 1'b0;
         last_q      <= '0;
         loop_cnt_q  <= '0;
         timeout_q   <= '0;
         cur_idx_q   <= '0;
         loop_idx_q  <= '0;
         err_q       <= 1'b0;
         any_valid_q <= 1'b0;
         pg_width_q  <= '0;
         pg_num_q    <= '0;
         pg_gap_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_q       <= run_i;
         last_q      <= last_d;
         loop_cnt_q  <= loop_cnt_d;
         timeout_q   <= timeout_d;
         cur_idx_q   <= cur_idx_d;
         loop_idx_q  <= loop_idx_d;
         err_q       <= err_d;
         any_valid_q <= any_valid_d;
         pg_width_q  <= pg_width_d;
         pg_num_q    <= pg_num_d;
         pg_gap_q    <= pg_gap_d;
      end
   end

   assign pg_width_o = pg_width_q;
   assign pg_num_o   = pg_num_q;
   assign pg_gap_o   = pg_gap_q;
   assign pg_start_o = (state_q == S_START);
   assign busy_o     = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign seq_done_o = (state_q == S_FINISH);
   assign cur_idx_o  = cur_idx_q;
   assign loop_idx_o = loop_idx_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Bench for pulse_burst_sched: directed scenarios plus randomized descriptor
// lists, with a list-level model of which descriptors must be executed.
module tb_pulse_burst_sched;

   localparam int DEPTH      = 8;
   localparam int AW         = 3;
   localparam int SETUP_CYC  = 4;
   localparam int START_HOLD = 4;
   localparam int TIMEOUT_W  = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cfg_we_i;
   logic [AW-1:0]        cfg_addr_i;
   logic [10:0]          cfg_width_i;
   logic [10:0]          cfg_num_i;
   logic [15:0]          cfg_gap_i;
   logic [AW:0]          seq_len_i;
   logic [7:0]           loop_cnt_i;
   logic [TIMEOUT_W-1:0] timeout_i;
   logic                 run_i;
   logic                 abort_i;
   logic [10:0]          pg_width_o;
   logic [10:0]          pg_num_o;
   logic [15:0]          pg_gap_o;
   logic                 pg_start_o;
   logic                 pg_done_i;
   logic                 busy_o;
   logic [AW-1:0]        cur_idx_o;
   logic [7:0]           loop_idx_o;
   logic                 seq_done_o;
   logic                 err_o;

   // Clock: 8 ns period.
   always #4 clk = ~clk;

   pulse_burst_sched #(
      .DEPTH(DEPTH), .AW(AW), .SETUP_CYC(SETUP_CYC),
      .START_HOLD(START_HOLD), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
      .cfg_width_i(cfg_width_i), .cfg_num_i(cfg_num_i), .cfg_gap_i(cfg_gap_i),
      .seq_len_i(seq_len_i), .loop_cnt_i(loop_cnt_i), .timeout_i(timeout_i),
      .run_i(run_i), .abort_i(abort_i),
      .pg_width_o(pg_width_o), .pg_num_o(pg_num_o), .pg_gap_o(pg_gap_o),
      .pg_start_o(pg_start_o), .pg_done_i(pg_done_i),
      .busy_o(busy_o), .cur_idx_o(cur_idx_o), .loop_idx_o(loop_idx_o),
      .seq_done_o(seq_done_o), .err_o(err_o)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [37:0] exp_q[$];
   logic [37:0] obs_q[$];
   logic [10:0] sh_w[DEPTH];
   logic [10:0] sh_n[DEPTH];
   logic [15:0] sh_g[DEPTH];

   int start_cnt   = 0;
   int done_cnt    = 0;
   int hi_cnt      = 0;
   int gen_cd      = 0;
   bit prev_start  = 1'b0;
   bit gen_respond = 1'b1;
   bit bad_load    = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Generator model and start monitor: records each burst issued, checks the
   // start strobe length, and returns done a random delay after start drops.
   initial begin : gen_mon
      pg_done_i = 1'b0;
      forever begin
         @(negedge clk);
         pg_done_i = 1'b0;
         if (gen_cd > 0) begin
            gen_cd--;
            if (gen_cd == 0) pg_done_i = 1'b1;
         end
         if (pg_start_o && !prev_start) begin
            obs_q.push_back({pg_width_o, pg_num_o, pg_gap_o});
            start_cnt++;
            hi_cnt = 1;
         end else if (pg_start_o) begin
            hi_cnt++;
         end else if (prev_start && rst_n) begin
            check("start_hold", 64'(hi_cnt), 64'(START_HOLD));
            if (gen_respond) gen_cd = int'($urandom_range(1, 6));
         end
         if (seq_done_o) done_cnt++;
         if (busy_o && pg_width_o == 11'd77) bad_load = 1'b1;
         prev_start = pg_start_o;
      end
   end

   // List-level reference: which descriptors run, in order, and how many passes finish.
   task automatic model_seq(input int len_raw, input int loops, input int max_n,
                            output int final_loop);
      int  len;
      int  pass;
      bit  anyv;
      len  = (len_raw == 0) ? 1 : ((len_raw > DEPTH) ? DEPTH : len_raw);
      exp_q.delete();
      pass = 0;
      while (1) begin
         anyv = 1'b0;
         for (int i = 0; i < len; i++) begin
            if (sh_w[i] != 0 && sh_n[i] != 0 && sh_g[i] != 0) begin
               anyv = 1'b1;
               if (exp_q.size() < max_n) exp_q.push_back({sh_w[i], sh_n[i], sh_g[i]});
            end
         end
         pass++;
         if (!anyv || (loops != 0 && pass >= loops) || exp_q.size() >= max_n) break;
      end
      final_loop = (pass > 255) ? 255 : pass;
   endtask

   task automatic wr(input int a, input int w, input int n, input int g, input bit upd);
      cfg_we_i    = 1'b1;
      cfg_addr_i  = AW'(a);
      cfg_width_i = 11'(w);
      cfg_num_i   = 11'(n);
      cfg_gap_i   = 16'(g);
      if (upd) begin
         sh_w[a] = 11'(w);
         sh_n[a] = 11'(n);
         sh_g[a] = 16'(g);
      end
      tick();
      cfg_we_i = 1'b0;
   endtask

   task automatic start_run(input int len, input int loops, input int tmo);
      seq_len_i  = (AW+1)'(len);
      loop_cnt_i = 8'(loops);
      timeout_i  = TIMEOUT_W'(tmo);
      obs_q.delete();
      start_cnt  = 0;
      done_cnt   = 0;
      run_i      = 1'b1;
      tick();
      run_i      = 1'b0;
   endtask

   task automatic wait_seq_done(input string tag, input int bound);
      int n;
      n = 0;
      while (!seq_done_o && n < bound) begin
         tick();
         n++;
      end
      check({tag, "_seq_done"}, 64'(seq_done_o), 64'(1));
      check({tag, "_busy_at_done"}, 64'(busy_o), 64'(0));
      tick();
      check({tag, "_done_one_cycle"}, 64'(seq_done_o), 64'(0));
      check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
   endtask

   task automatic cmp_seq(input string tag);
      int m;
      check({tag, "_nstarts"}, 64'(obs_q.size()), 64'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) check({tag, "_desc"}, 64'(obs_q[i]), 64'(exp_q[i]));
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL global_timeout: simulation did not finish, observed running, expected done");
      $fatal(1, "global timeout");
   end

   initial begin : main
      int li;
      int n;
      int s;
      int w;
      logic last_err;

      // Reset
      rst_n = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_width_i = '0;
      cfg_num_i = '0; cfg_gap_i = '0; seq_len_i = '0; loop_cnt_i = '0;
      timeout_i = '0; run_i = 1'b0; abort_i = 1'b0;
      repeat (3) tick();
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_start", 64'(pg_start_o), 64'(0));
      check("rst_seq_done", 64'(seq_done_o), 64'(0));
      check("rst_err", 64'(err_o), 64'(0));
      check("rst_cur_idx", 64'(cur_idx_o), 64'(0));
      check("rst_loop_idx", 64'(loop_idx_o), 64'(0));
      check("rst_pg_cfg", 64'({pg_width_o, pg_num_o, pg_gap_o}), 64'(0));
      rst_n = 1'b1;
      tick();

      // Single descriptor, written in the same cycle as the run edge.
      sh_w[0] = 11'd20; sh_n[0] = 11'd3; sh_g[0] = 16'd2;
      cfg_we_i = 1'b1; cfg_addr_i = '0; cfg_width_i = 11'd20; cfg_num_i = 11'd3; cfg_gap_i = 16'd2;
      seq_len_i = 4'd1; loop_cnt_i = 8'd1; timeout_i = '0;
      obs_q.delete(); start_cnt = 0; done_cnt = 0;
      run_i = 1'b1;
      tick();
      cfg_we_i = 1'b0; run_i = 1'b0;
      check("t1_busy", 64'(busy_o), 64'(1));
      n = 0;
      while (pg_width_o != 11'd20 && n < 20) begin tick(); n++; end
      s = 0;
      while (!pg_start_o && s < 20) begin tick(); s++; end
      check("t1_setup_cycles", 64'(s), 64'(SETUP_CYC));
      wait_seq_done("t1", 200);
      model_seq(1, 1, 100, li);
      cmp_seq("t1");
      check("t1_loop_idx", 64'(loop_idx_o), 64'(li));
      check("t1_err", 64'(err_o), 64'(0));

      // Invalid middle slot skipped over two passes.
      wr(0, 100, 5, 10, 1);
      wr(1, 77, 0, 20, 1);
      wr(2, 300, 7, 30, 1);
      bad_load = 1'b0;
      start_run(3, 2, 0);
      wait_seq_done("t2", 500);
      model_seq(3, 2, 100, li);
      cmp_seq("t2");
      check("t2_loop_idx", 64'(loop_idx_o), 64'(li));
      check("t2_slot1_never_loaded", 64'(bad_load), 64'(0));
      check("t2_cur_idx", 64'(cur_idx_o), 64'(0));

      // Endless loop stopped by abort during the fifth burst.
      wr(0, 111, 2, 3, 1);
      wr(1, 222, 4, 5, 1);
      start_run(2, 0, 0);
      n = 0;
      while (start_cnt < 5 && n < 1000) begin tick(); n++; end
      abort_i = 1'b1;
      wait_seq_done("t3", 300);
      abort_i = 1'b0;
      model_seq(2, 0, 5, li);
      cmp_seq("t3");
      check("t3_cur_idx", 64'(cur_idx_o), 64'((5 - 1) % 2));
      check("t3_loop_idx", 64'(loop_idx_o), 64'((5 - 1) / 2));

      // Watchdog expiry with a silent generator.
      gen_respond = 1'b0;
      wr(0, 50, 1, 9, 1);
      start_run(1, 1, 1000);
      n = 0;
      while (!(start_cnt >= 1 && !pg_start_o) && n < 100) begin tick(); n++; end
      w = 0;
      last_err = 1'b0;
      while (!seq_done_o && w < 1100) begin
         last_err = err_o;
         tick();
         w++;
      end
      check("t4_wait_cycles", 64'(w), 64'(1000));
      check("t4_err_before_expiry", 64'(last_err), 64'(0));
      check("t4_err_set", 64'(err_o), 64'(1));
      check("t4_seq_done", 64'(seq_done_o), 64'(1));
      tick();
      check("t4_done_one_cycle", 64'(seq_done_o), 64'(0));
      repeat (3) tick();
      check("t4_err_sticky", 64'(err_o), 64'(1));
      gen_respond = 1'b1;
      start_run(1, 1, 0);
      check("t4_err_cleared", 64'(err_o), 64'(0));
      wait_seq_done("t4b", 200);
      check("t4b_err", 64'(err_o), 64'(0));

      // Every descriptor invalid in endless mode: one pass, no bursts.
      for (int i = 0; i < DEPTH; i++) wr(i, 10 + i, 2, 0, 1);
      start_run(DEPTH, 0, 0);
      wait_seq_done("t5", 300);
      model_seq(DEPTH, 0, 100, li);
      check("t5_nstarts", 64'(start_cnt), 64'(exp_q.size()));
      check("t5_loop_idx", 64'(loop_idx_o), 64'(li));
      check("t5_cur_idx", 64'(cur_idx_o), 64'(0));

      // Reset while start is high.
      wr(0, 33, 2, 4, 1);
      start_run(1, 1, 0);
      n = 0;
      while (!pg_start_o && n < 50) begin tick(); n++; end
      rst_n = 1'b0;
      #1;
      check("t6_rst_start", 64'(pg_start_o), 64'(0));
      check("t6_rst_busy", 64'(busy_o), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // A write while busy is dropped.
      wr(0, 33, 2, 4, 1);
      start_run(1, 1, 0);
      check("t6_busy_before_write", 64'(busy_o), 64'(1));
      wr(0, 44, 5, 6, 0);
      wait_seq_done("t6a", 200);
      start_run(1, 1, 0);
      wait_seq_done("t6b", 200);
      model_seq(1, 1, 100, li);
      cmp_seq("t6b");

      // Randomized descriptor lists.
      for (int it = 0; it < 8; it++) begin
         int len;
         int loops;
         for (int i = 0; i < DEPTH; i++) begin
            wr(i,
               ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2047)),
               ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2047)),
               ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 65535)),
               1'b1);
         end
         len   = int'($urandom_range(0, 15));
         loops = int'($urandom_range(1, 3));
         start_run(len, loops, 0);
         wait_seq_done("rnd", 3000);
         model_seq(len, loops, 1000, li);
         cmp_seq("rnd");
         check("rnd_loop_idx", 64'(loop_idx_o), 64'(li));
         check("rnd_cur_idx", 64'(cur_idx_o), 64'(0));
         check("rnd_err", 64'(err_o), 64'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pulse_burst_sched.md
Name: pulse_burst_sched

Overview:
Sequencer that drives the OSERDES pulse generator through a programmed list of burst descriptors. Each descriptor holds pulse width, pulse count and inter-pulse gap. The block loads a descriptor onto the generator's configuration inputs, issues a start strobe, waits for the generator's done, then advances to the next descriptor. The whole list repeats a programmable number of times. It sits in the clk_div domain beside the generator and is programmed by the PS-side register block.

Parameters:
DEPTH, 8, number of descriptor slots (power of 2, 2..64)
AW, $clog2(DEPTH), descriptor address width
SETUP_CYC, 4, cycles descriptor is held stable before start is raised (covers generator input register stage)
START_HOLD, 4, cycles pg_start_o is held high (must exceed generator's 2-flop edge detector)
TIMEOUT_W, 32, width of done-watchdog counter

Ports:
clk  in  1  clock, same clock as generator clk_div (125 MHz)
rst_n  in  1  asynchronous active-low reset
cfg_we_i  in  1  descriptor write strobe (ignored while busy_o=1)
cfg_addr_i  in  AW  descriptor slot
cfg_width_i  in  11  pulse width in 1 ns bits
cfg_num_i  in  11  pulses per burst
cfg_gap_i  in  16  gap between pulses, us
seq_len_i  in  AW+1  active descriptors, 1..DEPTH; sampled at run
loop_cnt_i  in  8  list repetitions; 0 = loop forever; sampled at run
timeout_i  in  TIMEOUT_W  max cycles in WAIT_DONE; 0 = watchdog off
run_i  in  1  rising edge starts a sequence when idle
abort_i  in  1  level; stops sequence at the next safe point
pg_width_o  out  11  to generator pulse_width_i
pg_num_o  out  11  to generator pulse_num_i
pg_gap_o  out  16  to generator gap_us_i
pg_start_o  out  1  to generator start_i
pg_done_i  in  1  from generator done_o
busy_o  out  1  sequence in progress
cur_idx_o  out  AW  descriptor currently executing
loop_idx_o  out  8  completed list passes
seq_done_o  out  1  one-cycle pulse at normal completion or abort completion
err_o  out  1  sticky watchdog error; cleared by next accepted run

Behaviour:
- Reset: all outputs 0, state IDLE, descriptor RAM contents undefined. Reset mid-sequence returns to IDLE immediately; pg_start_o drops asynchronously.
- run edge: run_i registered once; start condition = run_i & ~run_q in IDLE only. Edges seen while busy are ignored.
- On start: latch seq_len (0 treated as 1; values >DEPTH clamp to DEPTH), loop_cnt and timeout. Clear err_o, cur_idx_o and loop_idx_o. Set busy_o.
- States:
  - IDLE -> CHECK on start.
  - CHECK: read descriptor[cur_idx]. If width==0, num==0 or gap==0, the descriptor is invalid; go to NEXT and skip it (gap==0 would wrap the generator's us counter). Otherwise go to LOAD.
  - LOAD: pg_width/num/gap_o driven from the descriptor. They stay stable until the next LOAD. Hold SETUP_CYC cycles, then go to START.
  - START: pg_start_o=1 for START_HOLD cycles, then 0, then go to WAIT_DONE.
  - WAIT_DONE: on pg_done_i=1, go to NEXT. If timeout!=0 and the counter reaches timeout, set err_o and go to FINISH.
  - NEXT: if abort_i, go to FINISH. Else if cur_idx==seq_len-1: increment loop_idx (saturate at 255) and reset cur_idx to 0. Then if loop_cnt!=0 and loop_idx+1==loop_cnt, go to FINISH; otherwise go to CHECK. Else increment cur_idx and go to CHECK.
  - FINISH: seq_done_o=1 for one cycle, busy_o=0, go to IDLE.
- Abort is sampled only in NEXT and in IDLE (where it has no effect). A running burst always completes, so the generator is never left mid-burst.
- Guard: if every descriptor is invalid for one full pass, go to FINISH after that pass. This applies even when loop_cnt=0, so the block cannot spin forever.
- pg_done_i is level-sampled. WAIT_DONE is entered at least START_HOLD cycles after start, so the generator's stale done is already low.
- Watchdog counter is TIMEOUT_W bits, reset on WAIT_DONE entry, and saturates.
- cfg writes during busy are dropped with no side effect. A cfg write and a run edge in the same cycle: the write lands first and is used.

Test Plan:
- Write slot0={w=20,n=3,g=2}, seq_len=1, loop=1, run -> pg_start_o high exactly 4 cycles after 4-cycle setup; after a model done, seq_done_o pulses once and busy_o=0.
- 3 slots, slot1 num=0, loop=2 -> execution order 0,2,0,2; loop_idx_o ends at 2; slot1 is never loaded onto pg_*_o.
- loop=0, 2 slots, abort asserted during the 5th burst -> that burst completes, then FINISH; exactly 5 starts issued.
- timeout=1000, generator model never returns done -> err_o=1 at cycle 1000 of WAIT_DONE, seq_done_o pulses; next run clears err_o.
- Every slot has gap=0, loop=0 -> FINISH after one pass with zero starts issued.
- rst_n low mid-START -> pg_start_o=0 and busy_o=0 at once; cfg write with busy=1 -> readback after idle shows the old value.
